// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared writeback-path types and widths for the register file write arbiter.
package regfile_wb_arbiter_pkg;

  localparam int XLEN    = 32;
  localparam int REG_AW  = 5;
  localparam int NUM_REQ = 2;

  // Requester indices; the ALU wins the first contention after reset.
  localparam logic REQ_ALU = 1'b0;
  localparam logic REQ_LSU = 1'b1;

  typedef struct packed {
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0]   data;
  } wb_req_t;

endpackage

// File: rtl/regfile_wb_arbiter_wb_slot.sv
// One-entry writeback holding buffer with valid/ready intake; refills in the cycle it drains.
module wb_slot
  import regfile_wb_arbiter_pkg::*;
(
  input  logic    clk,
  input  logic    rst,
  input  logic    clk_en,
  input  logic    in_valid,
  input  wb_req_t in_req,
  output logic    in_ready,
  input  logic    grant,
  output logic    buf_v,
  output wb_req_t buf_q
);

  assign in_ready = clk_en & ~rst & (~buf_v | grant);

  always_ff @(posedge clk) begin
    if (rst) begin
      buf_v <= 1'b0;
      buf_q <= '0;
    end else if (clk_en) begin
      if (in_valid && in_ready) begin
        // x0 writes are swallowed: accepted upstream but never held.
        buf_v <= (in_req.rd != '0);
        buf_q <= in_req;
      end else if (grant) begin
        buf_v <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Round-robin share of the register file write port between ALU and LSU writeback.
module regfile_wb_arbiter #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clk_en,
  input  logic                 alu_valid,
  output logic                 alu_ready,
  input  logic [REG_AW-1:0]    alu_rd,
  input  logic [XLEN-1:0]      alu_data,
  input  logic                 lsu_valid,
  output logic                 lsu_ready,
  input  logic [REG_AW-1:0]    lsu_rd,
  input  logic [XLEN-1:0]      lsu_data,
  output logic                 rf_we,
  output logic [REG_AW-1:0]    rf_rd_addr,
  output logic [XLEN-1:0]      rf_data,
  output logic [2**REG_AW-1:0] pending
);
  import regfile_wb_arbiter_pkg::*;

  logic [NUM_REQ-1:0] in_valid, in_ready, grant, buf_v;
  wb_req_t            in_req [NUM_REQ];
  wb_req_t            buf_q  [NUM_REQ];
  logic               last_grant;

  assign in_valid = {lsu_valid, alu_valid};
  assign in_req[REQ_ALU] = '{rd: alu_rd, data: alu_data};
  assign in_req[REQ_LSU] = '{rd: lsu_rd, data: lsu_data};
  assign alu_ready = in_ready[REQ_ALU];
  assign lsu_ready = in_ready[REQ_LSU];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_slot
    wb_slot u_slot (
      .clk      (clk),
      .clk_en   (clk_en),
      .rst      (rst),
      .in_valid (in_valid[i]),
      .in_req   (in_req[i]),
      .in_ready (in_ready[i]),
      .grant    (grant[i]),
      .buf_v    (buf_v[i]),
      .buf_q    (buf_q[i])
    );
  end

  // Grants are qualified by clk_en: the register file forwards on we alone.
  always_comb begin
    grant = '0;
    if (clk_en && !rst) begin
      if (&buf_v) grant[~last_grant] = 1'b1;
      else        grant = buf_v;
    end
  end

  assign rf_we      = |grant;
  assign rf_rd_addr = grant[REQ_LSU] ? buf_q[REQ_LSU].rd   : buf_q[REQ_ALU].rd;
  assign rf_data    = grant[REQ_LSU] ? buf_q[REQ_LSU].data : buf_q[REQ_ALU].data;

  always_ff @(posedge clk) begin
    if (rst)                   last_grant <= REQ_LSU;
    else if (clk_en && rf_we)  last_grant <= grant[REQ_LSU];
  end

  always_comb begin
    pending = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (buf_v[i]) pending[buf_q[i].rd] = 1'b1;
    pending[0] = 1'b0;
  end

endmodule
